// File: rtl/note_sequencer.sv
// Note command FIFO and playback FSM feeding the tone generator.
// Drives period/enable for each queued note; supports gap, pause and flush.
module note_sequencer #(
    parameter int DEPTH      = 8,
    parameter int GAP_CYCLES = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [23:0]              in_period,
    input  logic [23:0]              in_duration,
    input  logic                     play_en,
    input  logic                     flush,
    output logic [23:0]              tone_switch_period,
    output logic                     output_enable,
    output logic                     note_done,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [23:0] GAP_LEN  = 24'(GAP_CYCLES);

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    logic [47:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, empty, push, pop, load;

    state_t        state_q, state_d;
    logic [23:0]   rem_q, rem_d;
    logic [23:0]   gap_q, gap_d;
    logic [23:0]   period_q, period_d;
    logic          oe_q, oe_d;
    logic          done_q, done_d;

    logic [23:0]   head_p, head_d;
    logic          can_pop, last;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign push    = in_valid && !full && !flush;
    assign head_p  = mem[rd_ptr][47:24];
    assign head_d  = mem[rd_ptr][23:0];
    assign can_pop = play_en && !empty;
    assign last    = oe_q && (rem_q == 24'd1);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {in_period, in_duration};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            gap_q    <= '0;
            period_q <= '0;
            oe_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            gap_q    <= gap_d;
            period_q <= period_d;
            oe_q     <= oe_d;
            done_q   <= done_d;
        end
    end

    // Zero-length notes are popped and dropped without ever playing.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (can_pop) begin
                    pop = 1'b1;
                    if (head_d != '0) begin
                        load    = 1'b1;
                        state_d = PLAY;
                    end
                end
            end
            PLAY: begin
                if (last) begin
                    if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                    end else if (can_pop) begin
                        pop = 1'b1;
                        if (head_d != '0)
                            load = 1'b1;
                        else
                            state_d = IDLE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            GAP: begin
                if (play_en && gap_q <= 24'd1)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
            pop     = 1'b0;
            load    = 1'b0;
        end
    end

    // Enable is registered: it reflects play_en of the previous cycle.
    always_comb begin
        rem_d    = rem_q;
        gap_d    = gap_q;
        period_d = period_q;
        oe_d     = 1'b0;
        done_d   = 1'b0;
        if (load) begin
            period_d = head_p;
            rem_d    = head_d;
            oe_d     = 1'b1;
            done_d   = (head_d == 24'd1);
        end else begin
            case (state_q)
                PLAY: begin
                    if (!last) begin
                        if (oe_q)
                            rem_d = rem_q - 24'd1;
                        oe_d   = play_en;
                        done_d = play_en && (rem_d == 24'd1);
                    end else if (state_d == GAP) begin
                        gap_d = GAP_LEN;
                    end
                end
                GAP: begin
                    if (play_en && gap_q != '0)
                        gap_d = gap_q - 24'd1;
                end
                default: ;
            endcase
        end
        if (flush) begin
            rem_d    = '0;
            gap_d    = '0;
            period_d = '0;
            oe_d     = 1'b0;
            done_d   = 1'b0;
        end
    end

    assign in_ready           = !full;
    assign tone_switch_period = period_q;
    assign output_enable      = oe_q;
    assign note_done          = done_q;
    assign busy               = (state_q != IDLE) || !empty;
    assign fifo_count         = count;

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: one instance without gap, one with.
// Each enabled output cycle is checked against a queue of expected samples.
module tb_note_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        v0, pe0, fl0, rdy0, oe0, nd0, bz0;
    logic [23:0] p0, d0, tsp0;
    logic [3:0]  cnt0;
    logic        v3, pe3, fl3, rdy3, oe3, nd3, bz3;
    logic [23:0] p3, d3, tsp3;
    logic [3:0]  cnt3;

    note_sequencer #(.DEPTH(8), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(v0), .in_ready(rdy0),
        .in_period(p0), .in_duration(d0), .play_en(pe0), .flush(fl0),
        .tone_switch_period(tsp0), .output_enable(oe0),
        .note_done(nd0), .busy(bz0), .fifo_count(cnt0)
    );

    note_sequencer #(.DEPTH(8), .GAP_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(v3), .in_ready(rdy3),
        .in_period(p3), .in_duration(d3), .play_en(pe3), .flush(fl3),
        .tone_switch_period(tsp3), .output_enable(oe3),
        .note_done(nd3), .busy(bz3), .fifo_count(cnt3)
    );

    typedef struct packed {
        logic [23:0] p;
        logic        done;
    } exp_t;

    exp_t sb0[$];
    exp_t sb3[$];
    int   checks   = 0;
    int   failures = 0;
    int   en_tot, rise_tot;
    logic prev_oe;
    logic [31:0] pat;

    task automatic chk(input string name, input logic [47:0] act,
                       input logic [47:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic exp_note(input int which, input logic [23:0] p,
                            input int d);
        exp_t e;
        for (int i = 0; i < d; i++) begin
            e.p    = p;
            e.done = (i == d - 1);
            if (which == 0) sb0.push_back(e);
            else            sb3.push_back(e);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_count(input int which, input int n);
        logic o;
        for (int i = 0; i < n; i++) begin
            tick();
            o = (which == 0) ? oe0 : oe3;
            if (o) en_tot++;
            if (o && !prev_oe) rise_tot++;
            prev_oe = o;
            pat = {pat[30:0], o};
        end
    endtask

    task automatic clr_stats;
        en_tot   = 0;
        rise_tot = 0;
        prev_oe  = 1'b0;
        pat      = '0;
    endtask

    exp_t m0, m3;

    always @(negedge clk) begin
        if (rst) begin
            if (oe0) begin
                if (sb0.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb0_unexpected actual=%0d required=none",
                             tsp0);
                end else begin
                    m0 = sb0.pop_front();
                    chk("sb0_period", 48'(tsp0), 48'(m0.p));
                    chk("sb0_done", 48'(nd0), 48'(m0.done));
                end
            end else if (nd0) begin
                chk("sb0_done_no_oe", 48'(nd0), 48'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (oe3) begin
                if (sb3.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb3_unexpected actual=%0d required=none",
                             tsp3);
                end else begin
                    m3 = sb3.pop_front();
                    chk("sb3_period", 48'(tsp3), 48'(m3.p));
                    chk("sb3_done", 48'(nd3), 48'(m3.done));
                end
            end else if (nd3) begin
                chk("sb3_done_no_oe", 48'(nd3), 48'd0);
            end
        end
    end

    initial begin
        v0 = 0; p0 = 0; d0 = 0; pe0 = 1; fl0 = 0;
        v3 = 0; p3 = 0; d3 = 0; pe3 = 1; fl3 = 0;
        clr_stats();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_oe", 48'(oe0), 48'd0);
        chk("rst_period", 48'(tsp0), 48'd0);
        chk("rst_done", 48'(nd0), 48'd0);
        chk("rst_count", 48'(cnt0), 48'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("rst_ready", 48'(rdy0), 48'd1);
        chk("rst_busy", 48'(bz0), 48'd0);

        // single note latency
        v0 = 1; p0 = 1000; d0 = 5;
        exp_note(0, 1000, 5);
        tick();
        v0 = 0;
        chk("t1_oe_n1", 48'(oe0), 48'd0);
        tick();
        chk("t1_oe_n2", 48'(oe0), 48'd1);
        chk("t1_period_n2", 48'(tsp0), 48'd1000);
        repeat (4) tick();
        chk("t1_done_n6", 48'(nd0), 48'd1);
        tick();
        chk("t1_oe_n7", 48'(oe0), 48'd0);
        chk("t1_busy_n7", 48'(bz0), 48'd0);

        // back-to-back notes, including a rest
        clr_stats();
        v0 = 1; p0 = 100; d0 = 3; exp_note(0, 100, 3);
        run_count(0, 1);
        p0 = 200; d0 = 2; exp_note(0, 200, 2);
        run_count(0, 1);
        p0 = 0; d0 = 2; exp_note(0, 0, 2);
        run_count(0, 1);
        v0 = 0;
        run_count(0, 12);
        chk("t2_enabled", 48'(en_tot), 48'd7);
        chk("t2_rises", 48'(rise_tot), 48'd1);
        chk("t2_sb_empty", 48'(sb0.size()), 48'd0);

        // fill to full while paused
        pe0 = 0;
        for (int i = 0; i < 9; i++) begin
            v0 = 1; p0 = 24'(10 + i); d0 = 1;
            if (i < 8) exp_note(0, 24'(10 + i), 1);
            tick();
            if (i == 7) begin
                chk("t3_ready_at8", 48'(rdy0), 48'd0);
                chk("t3_count_at8", 48'(cnt0), 48'd8);
            end
        end
        chk("t3_count_after9", 48'(cnt0), 48'd8);
        clr_stats();
        p0 = 99; d0 = 1; pe0 = 1;
        run_count(0, 1);
        v0 = 0;
        chk("t3_pushpop_full", 48'(cnt0), 48'd7);
        run_count(0, 12);
        chk("t3_enabled", 48'(en_tot), 48'd8);
        chk("t3_busy", 48'(bz0), 48'd0);
        chk("t3_sb_empty", 48'(sb0.size()), 48'd0);

        // pause mid-note
        clr_stats();
        v0 = 1; p0 = 500; d0 = 10; exp_note(0, 500, 10);
        run_count(0, 1);
        v0 = 0;
        run_count(0, 3);
        pe0 = 0;
        run_count(0, 4);
        pe0 = 1;
        run_count(0, 16);
        chk("t4_enabled", 48'(en_tot), 48'd10);
        chk("t4_rises", 48'(rise_tot), 48'd2);
        chk("t4_sb_empty", 48'(sb0.size()), 48'd0);

        // gap instance: two short notes then a zero-length one
        clr_stats();
        v3 = 1; p3 = 10; d3 = 2; exp_note(1, 10, 2);
        run_count(1, 1);
        p3 = 20; exp_note(1, 20, 2);
        run_count(1, 1);
        v3 = 0;
        run_count(1, 8);
        chk("t5_pattern", 48'(pat[9:0]), 48'(10'b0110000110));
        clr_stats();
        v3 = 1; p3 = 30; d3 = 0;
        run_count(1, 1);
        v3 = 0;
        run_count(1, 6);
        chk("t5_zero_enabled", 48'(en_tot), 48'd0);
        chk("t5_zero_count", 48'(cnt3), 48'd0);
        chk("t5_zero_busy", 48'(bz3), 48'd0);
        chk("t5_sb_empty", 48'(sb3.size()), 48'd0);

        // flush during play with queued notes and a same-cycle push
        v0 = 1; p0 = 700; d0 = 20; exp_note(0, 700, 20);
        tick();
        p0 = 1; d0 = 5; tick();
        p0 = 2; tick();
        p0 = 3; tick();
        chk("t6_count_before", 48'(cnt0), 48'd3);
        chk("t6_oe_before", 48'(oe0), 48'd1);
        fl0 = 1; p0 = 4;
        tick();
        fl0 = 0; v0 = 0;
        sb0.delete();
        chk("t6_count", 48'(cnt0), 48'd0);
        chk("t6_oe", 48'(oe0), 48'd0);
        chk("t6_period", 48'(tsp0), 48'd0);
        chk("t6_busy", 48'(bz0), 48'd0);
        tick();
        chk("t6_count_later", 48'(cnt0), 48'd0);
        chk("t6_oe_later", 48'(oe0), 48'd0);

        // asynchronous reset mid-note
        v0 = 1; p0 = 800; d0 = 50; exp_note(0, 800, 50);
        tick();
        v0 = 0;
        repeat (4) tick();
        chk("t7_oe_before", 48'(oe0), 48'd1);
        #2 rst = 1'b0;
        #1;
        chk("t7_oe_async", 48'(oe0), 48'd0);
        chk("t7_period_async", 48'(tsp0), 48'd0);
        chk("t7_busy_async", 48'(bz0), 48'd0);
        chk("t7_count_async", 48'(cnt0), 48'd0);
        sb0.delete();
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("t7_oe_after", 48'(oe0), 48'd0);
        chk("t7_ready_after", 48'(rdy0), 48'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Upstream feeder for the audio tone generator: buffers (period, duration) note commands from the CPU MMIO path in a FIFO.
- Plays them back in order by driving the generator's tone_switch_period and output_enable for each note's duration in clk cycles.
- Supports an optional silent inter-note gap, pause, and flush.
- Sits between the memory-mapped audio registers and the tone generator.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- GAP_CYCLES, 0, silent cycles inserted after each note; 0 = back-to-back notes.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- in_valid  input  1  note command valid.
- in_ready  output  1  FIFO can accept; equals !full.
- in_period  input  24  tone switch period for the note; 0 = rest.
- in_duration  input  24  note length in clk cycles.
- play_en  input  1  1 = play/advance, 0 = pause.
- flush  input  1  synchronous clear of FIFO and FSM.
- tone_switch_period  output  24  registered; to tone generator.
- output_enable  output  1  registered; to tone generator.
- note_done  output  1  one-cycle pulse on the last PLAY cycle of each note.
- busy  output  1  FSM not IDLE or FIFO not empty.
- fifo_count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst=0, asynchronous): FIFO empty, FSM IDLE, tone_switch_period=0, output_enable=0, note_done=0, fifo_count=0; in_ready=1 after release.
- Push: occurs when in_valid && in_ready. {in_period, in_duration} is written at the tail.
- Full: in_ready=0 and the push is dropped. A same-cycle pop does not make room that cycle.
- Simultaneous push and pop: fifo_count is unchanged. An entry pushed into an empty FIFO is poppable on the next cycle, not the same one.
- Flush: has priority over push, pop and FSM. Next cycle: FIFO empty, FSM IDLE, outputs 0. The push in the flush cycle is discarded.
- IDLE: output_enable=0; tone_switch_period holds its last value.
  - If play_en && !empty: pop the head.
  - If the popped duration is 0: discard it and stay IDLE.
  - Otherwise load period and remaining=duration, and go to PLAY.
  - Latency: a push into an empty idle FIFO at cycle N pops at N+1; output_enable=1 at N+2.
- PLAY: output_enable=1, tone_switch_period=loaded period (period 0 passes through as a rest).
  - Each cycle with play_en=1, remaining decrements.
  - On the cycle remaining==1: assert note_done. Exactly `duration` cycles have output_enable=1.
  - Next state after the last cycle:
    - GAP_CYCLES>0: go to GAP.
    - GAP_CYCLES=0 and FIFO non-empty: pop the next entry in the same cycle and stay in PLAY with the new period; no idle cycle between notes.
    - GAP_CYCLES=0 and FIFO empty: go to IDLE.
- Pause: play_en=0 in PLAY forces output_enable=0 and freezes remaining. Setting play_en=1 resumes with the remaining count; paused cycles do not count.
- GAP: output_enable=0 for exactly GAP_CYCLES cycles, then IDLE. play_en=0 freezes the gap counter.
- Width rule: counters are 24-bit unsigned; duration 0xFFFFFF is legal; no wrap.
- Reset asserted mid-note: immediate return to reset values, FIFO contents lost.

Test Plan:
- Reset, then push (period=1000, duration=5) at cycle N with play_en=1 -> output_enable=1 and tone_switch_period=1000 on cycles N+2..N+6; note_done pulse at N+6; output_enable=0 at N+7; busy=0 at N+7.
- GAP_CYCLES=0; push (100,3), (200,2), (0,2) back-to-back -> output_enable high for 7 consecutive cycles; period sequence 100,100,100,200,200,0,0; three note_done pulses.
- DEPTH=8 with play_en=0; push 9 notes -> in_ready=0 after the 8th, 9th dropped, fifo_count=8. Simultaneous push+pop at full does not accept the push.
- Note duration=10 with play_en dropped for 4 cycles mid-note -> output_enable=0 during the pause; total enabled cycles = 10; note_done only at true end.
- GAP_CYCLES=3; two notes of duration 2 -> pattern enable 1,1,0,0,0, then IDLE pop cycle, then 1,1. Also push duration=0 -> popped with no enable cycle and no note_done.
- Flush asserted during PLAY with 3 queued and a push the same cycle -> next cycle fifo_count=0, output_enable=0, period=0, busy=0. Async rst low mid-note -> outputs 0 without a clock edge.
